// File: rtl/uart_ram_loader.sv
// rtl/uart_ram_loader.sv - 8N1 UART receiver that loads a length-prefixed big-endian word image into RAM.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the data words.
module uart_ram_loader #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_w_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] MAX_WORDS    = 32'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERROR} ld_state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR} ld_state_t;
`endif

  rx_state_t   rx_state;
  logic        rx_meta, rx_s;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  rx_shift;
  logic        byte_valid, frame_err;

  ld_state_t   ld_state;
  logic [7:0]  hdr_hi, word_hi;
  logic [15:0] words_left;
  logic [15:0] hdr_word;

  assign hdr_word = {hdr_hi, rx_shift};

  // Receiver: mid-bit sampling referenced to the synchronized start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt  <= '0;
            bit_idx <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt     <= '0;
            rx_state   <= RX_IDLE;
            byte_valid <= rx_s;
            frame_err  <= !rx_s;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state   <= HDR_HI;
      ram_w_en   <= 1'b0;
      ram_addr   <= BASE;
      ram_w_data <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      hdr_hi     <= '0;
      word_hi    <= '0;
      words_left <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      ram_w_en <= 1'b0;
      if (frame_err && ld_state != DONE && ld_state != ERROR) begin
        ld_state   <= ERROR;
        busy       <= 1'b0;
        load_error <= 1'b1;
      end else begin
        case (ld_state)
          HDR_HI: if (byte_valid) begin
            hdr_hi   <= rx_shift;
`ifdef LOADER_CHECKSUM_EN
            csum     <= rx_shift;
`endif
            ld_state <= HDR_LO;
          end
          HDR_LO: if (byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_shift;
`endif
            if (hdr_word == 16'd0) begin
              ld_state  <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else if ({16'd0, hdr_word} > MAX_WORDS) begin
              ld_state   <= ERROR;
              load_error <= 1'b1;
            end else begin
              words_left <= hdr_word;
              busy       <= 1'b1;
              ld_state   <= DATA_HI;
            end
          end
          DATA_HI: if (byte_valid) begin
            word_hi  <= rx_shift;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_shift;
`endif
            ld_state <= DATA_LO;
          end
          DATA_LO: if (byte_valid) begin
            ram_w_en   <= 1'b1;
            ram_w_data <= {word_hi, rx_shift};
`ifdef LOADER_CHECKSUM_EN
            csum       <= csum ^ rx_shift;
`endif
            ld_state   <= WRITE;
          end
          // Strobe cycle: advance the address once the word has been presented.
          WRITE: begin
            ram_addr   <= ram_addr + 1'b1;
            words_left <= words_left - 1'b1;
            if (words_left == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
              ld_state  <= CHK;
`else
              ld_state  <= DONE;
              busy      <= 1'b0;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
`endif
            end else begin
              ld_state <= DATA_HI;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHK: if (byte_valid) begin
            busy <= 1'b0;
            if (rx_shift == csum) begin
              ld_state  <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              ld_state   <= ERROR;
              load_error <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// tb/tb_uart_ram_loader.sv - scoreboard bench for uart_ram_loader (16 clocks per bit).
module tb_uart_ram_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        ram_w_en;
  logic [11:0] ram_addr;
  logic [15:0] ram_w_data;
  logic        cpu_hold, busy, load_done, load_error;

  int total = 0;
  int bad = 0;
  int dbl_wr = 0;
  logic prev_we = 1'b0;
  logic [27:0] exp_q[$];
  logic [27:0] got_q[$];

  uart_ram_loader #(.CLK_HZ(1600000), .BAUD(100000), .ADDR_WIDTH(12), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .ram_w_en(ram_w_en), .ram_addr(ram_addr),
    .ram_w_data(ram_w_data), .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done),
    .load_error(load_error)
  );

  initial forever #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_w_en) got_q.push_back({ram_addr, ram_w_data});
    if (ram_w_en && prev_we) dbl_wr++;
    prev_we = ram_w_en;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bits(b);
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ram_w_en, ram_addr, ram_w_data, cpu_hold, busy, load_done, load_error} !== {1'b0, 12'h0, 16'h0, 4'b1000}) begin
      bad++;
      $display("FAIL reset_values got=%h exp=%h",
               {ram_w_en, ram_addr, ram_w_data, cpu_hold, busy, load_done, load_error}, {1'b0, 12'h0, 16'h0, 4'b1000});
    end
  endtask

  task automatic test_basic();
    logic found;
    logic [27:0] e, g;
    do_reset();
    exp_q.push_back({12'd0, 16'h1234});
    exp_q.push_back({12'd1, 16'hABCD});
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    total++;
    if ({busy, cpu_hold} !== 2'b11) begin
      bad++; $display("FAIL basic_busy got=%b exp=11", {busy, cpu_hold});
    end
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hCD, 1'b1);
    send_byte(8'h42, 1'b1);
`else
    send_bits(8'hCD);
    rx = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (ram_w_en) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL basic_strobe_timeout got=0 exp=1");
    end else begin
      total++;
      if ({load_done, cpu_hold} !== 2'b01) begin
        bad++; $display("FAIL basic_done_early got=%b exp=01", {load_done, cpu_hold});
      end
      @(negedge clk);
      total++;
      if ({load_done, cpu_hold, busy} !== 3'b100) begin
        bad++; $display("FAIL basic_done_next got=%b exp=100", {load_done, cpu_hold, busy});
      end
    end
    repeat (20) @(negedge clk);
`endif
    total++;
    if ({load_done, cpu_hold, load_error} !== 3'b100) begin
      bad++; $display("FAIL basic_final got=%b exp=100", {load_done, cpu_hold, load_error});
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL basic_write got=%h exp=%h", g, e); end
    end
    total++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      bad++; $display("FAIL basic_write_count left_exp=%0d extra_got=%0d exp=0", exp_q.size(), got_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_empty();
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    total++;
    if ({load_done, cpu_hold, busy, load_error} !== 4'b1000) begin
      bad++; $display("FAIL empty_done got=%b exp=1000", {load_done, cpu_hold, busy, load_error});
    end
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    total++;
    if ({load_done, cpu_hold, load_error} !== 3'b100 || got_q.size() != 0) begin
      bad++; $display("FAIL empty_ignore got=%b writes=%0d exp=100 writes=0", {load_done, cpu_hold, load_error}, got_q.size());
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'h10, 1'b1);
    send_byte(8'h01, 1'b1);
    total++;
    if ({load_error, cpu_hold, busy, load_done} !== 4'b1100 || got_q.size() != 0) begin
      bad++; $display("FAIL oversize_4097 got=%b writes=%0d exp=1100 writes=0", {load_error, cpu_hold, busy, load_done}, got_q.size());
    end
    do_reset();
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    total++;
    if ({load_error, busy} !== 2'b01) begin
      bad++; $display("FAIL size_4096_accept got=%b exp=01", {load_error, busy});
    end
  endtask

  task automatic test_framing();
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (20) @(negedge clk);
    total++;
    if ({load_error, cpu_hold, busy, load_done} !== 4'b1100 || got_q.size() != 0) begin
      bad++; $display("FAIL framing_err got=%b writes=%0d exp=1100 writes=0", {load_error, cpu_hold, busy, load_done}, got_q.size());
    end
    do_reset();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    total++;
    if ({load_error, busy, load_done} !== 3'b000) begin
      bad++; $display("FAIL glitch_quiet got=%b exp=000", {load_error, busy, load_done});
    end
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    total++;
    if ({load_done, load_error} !== 2'b10) begin
      bad++; $display("FAIL glitch_no_byte got=%b exp=10", {load_done, load_error});
    end
  endtask

  task automatic test_reset_midload();
    logic [27:0] e, g;
    do_reset();
    exp_q.push_back({12'd0, 16'h1122});
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midload_busy got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    total++;
    if ({ram_w_en, ram_addr, ram_w_data, cpu_hold, busy, load_done, load_error} !== {1'b0, 12'h0, 16'h0, 4'b1000}) begin
      bad++;
      $display("FAIL midload_reset got=%h exp=%h",
               {ram_w_en, ram_addr, ram_w_data, cpu_hold, busy, load_done, load_error}, {1'b0, 12'h0, 16'h0, 4'b1000});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back({12'd0, 16'h55AA});
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hFE, 1'b1);
`endif
    total++;
    if ({load_done, cpu_hold, load_error} !== 3'b100) begin
      bad++; $display("FAIL reload_done got=%b exp=100", {load_done, cpu_hold, load_error});
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL reload_write got=%h exp=%h", g, e); end
    end
    total++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      bad++; $display("FAIL reload_write_count left_exp=%0d extra_got=%0d exp=0", exp_q.size(), got_q.size());
      exp_q.delete();
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [27:0] e, g;
    do_reset();
    exp_q.push_back({12'd0, 16'h1234});
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h27, 1'b1);
    total++;
    if ({load_done, cpu_hold, load_error} !== 3'b100) begin
      bad++; $display("FAIL csum_good got=%b exp=100", {load_done, cpu_hold, load_error});
    end
    do_reset();
    exp_q.push_back({12'd0, 16'h1234});
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h00, 1'b1);
    total++;
    if ({load_error, cpu_hold, load_done} !== 3'b110) begin
      bad++; $display("FAIL csum_bad got=%b exp=110", {load_error, cpu_hold, load_done});
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL csum_write got=%h exp=%h", g, e); end
    end
    total++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      bad++; $display("FAIL csum_write_count left_exp=%0d extra_got=%0d exp=0", exp_q.size(), got_q.size());
      exp_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_oversize();
    test_framing();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    total++;
    if (dbl_wr !== 0) begin bad++; $display("FAIL back_to_back_strobe got=%0d exp=0", dbl_wr); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
